// File: rtl/timer_pkg.sv
// Shared types and defaults for the programmable tick timer.
// Optional capture register is enabled by defining TIMER_CAPTURE_EN.
package timer_pkg;

   typedef enum logic [1:0] {
      TMR_IDLE   = 2'd0,
      TMR_ACTIVE = 2'd1,
      TMR_DONE   = 2'd2
   } timer_state_t;

   typedef enum logic {
      MODE_PERIODIC = 1'b0,
      MODE_ONESHOT  = 1'b1
   } timer_mode_t;

   localparam int unsigned DEFAULT_CLK_FREQ = 10_000_000;

endpackage

// File: rtl/tick_counter.sv
// Count register with terminal compare and registered one-cycle tick.
// restart dominates advance; terminal is the combinational count==period match.
module tick_counter #(
   parameter int unsigned CNT_W = 24
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             advance,
   input  logic             restart,
   input  logic [CNT_W-1:0] period,
   output logic             terminal,
   output logic [CNT_W-1:0] count,
   output logic             tick
);

   assign terminal = (count == period);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (restart) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (advance) begin
         if (terminal) begin
            count <= '0;
            tick  <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
            tick  <= 1'b0;
         end
      end else begin
         tick <= 1'b0;
      end
   end

endmodule

// File: rtl/prog_tick_timer.sv
// Programmable tick timer: periodic/one-shot tick generator with pause, clear and reload.
// Define TIMER_CAPTURE_EN to add the capture / capture_val snapshot port pair.
module prog_tick_timer
   import timer_pkg::*;
#(
   parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
   parameter int unsigned CNT_W    = 24
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             enable,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_period,
   input  logic             mode,
   output logic             tick,
   output logic [CNT_W-1:0] count,
   output logic             done,
   output logic             running
`ifdef TIMER_CAPTURE_EN
   ,
   input  logic             capture,
   output logic [CNT_W-1:0] capture_val
`endif
);

   localparam logic [1:0] ST_IDLE   = TMR_IDLE;
   localparam logic [1:0] ST_ACTIVE = TMR_ACTIVE;
   localparam logic [1:0] ST_DONE   = TMR_DONE;

   localparam longint unsigned MAX_PERIOD   = (longint'(1) << CNT_W) - 1;
   localparam longint unsigned RESET_P_WIDE = longint'(CLK_FREQ) - 1;
   localparam logic [CNT_W-1:0] RESET_PERIOD = CNT_W'(CLK_FREQ - 1);

   generate
      if (RESET_P_WIDE > MAX_PERIOD) begin : g_bad_cfg
         $error("prog_tick_timer: CLK_FREQ-1 does not fit in CNT_W bits");
      end
   endgenerate

   logic [1:0]       state;
   logic [CNT_W-1:0] period_q;
   logic             advance;
   logic             restart;
   logic             terminal;

   assign advance = enable && (state != ST_DONE);
   assign restart = load || clear;
   assign running = (state == ST_ACTIVE) && enable;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         period_q <= RESET_PERIOD;
      end else if (load) begin
         period_q <= load_period;
      end
   end

   // Mode is only looked at on the terminal edge, so mid-count changes wait for the next wrap.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else if (restart) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else if (advance) begin
         if (terminal && (mode == MODE_ONESHOT)) begin
            state <= ST_DONE;
            done  <= 1'b1;
         end else begin
            state <= ST_ACTIVE;
         end
      end
   end

   tick_counter #(
      .CNT_W (CNT_W)
   ) u_tick_counter (
      .clk      (clk),
      .n_rst    (n_rst),
      .advance  (advance),
      .restart  (restart),
      .period   (period_q),
      .terminal (terminal),
      .count    (count),
      .tick     (tick)
   );

`ifdef TIMER_CAPTURE_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         capture_val <= '0;
      end else if (capture) begin
         capture_val <= count;
      end
   end
`endif

endmodule

// File: tb/tb_prog_tick_timer.sv
// Directed self-checking bench for prog_tick_timer with CLK_FREQ=10 (reset period 9).
// Capture checks are compiled in when TIMER_CAPTURE_EN is defined.
module tb_prog_tick_timer;

   localparam int unsigned CNT_W = 24;

   logic             clk;
   logic             n_rst;
   logic             enable;
   logic             clear;
   logic             load;
   logic [CNT_W-1:0] load_period;
   logic             mode;
   logic             tick;
   logic [CNT_W-1:0] count;
   logic             done;
   logic             running;
`ifdef TIMER_CAPTURE_EN
   logic             capture;
   logic [CNT_W-1:0] capture_val;
`endif

   int errors = 0;
   int checks = 0;

   prog_tick_timer #(
      .CLK_FREQ (10),
      .CNT_W    (CNT_W)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .enable      (enable),
      .clear       (clear),
      .load        (load),
      .load_period (load_period),
      .mode        (mode),
      .tick        (tick),
      .count       (count),
      .done        (done),
      .running     (running)
`ifdef TIMER_CAPTURE_EN
      ,
      .capture     (capture),
      .capture_val (capture_val)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_ctd(input string tag, input int ec, input logic et, input logic ed);
      chk({tag, ".count"}, 32'(count), 32'(ec));
      chk({tag, ".tick"},  32'(tick),  32'(et));
      chk({tag, ".done"},  32'(done),  32'(ed));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_rst       = 1'b0;
      enable      = 1'b0;
      clear       = 1'b0;
      load        = 1'b0;
      load_period = '0;
      mode        = 1'b0;
`ifdef TIMER_CAPTURE_EN
      capture     = 1'b0;
`endif
      #3;
      chk_ctd("reset", 0, 1'b0, 1'b0);
      chk("reset.running", 32'(running), 32'd0);
      #5;
      n_rst  = 1'b1;
      enable = 1'b1;

      // Default period 9: ticks after edges 10, 20, 30.
      for (int i = 1; i <= 30; i++) begin
         step();
         chk_ctd($sformatf("dflt_e%0d", i), i % 10, (i % 10) == 0, 1'b0);
      end
      chk("dflt.running", 32'(running), 32'd1);

      // Load P=3: tick every 4 enabled edges.
      load = 1'b1; load_period = 24'd3;
      step();
      chk_ctd("ld3", 0, 1'b0, 1'b0);
      load = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         step();
         chk_ctd($sformatf("p3_e%0d", i), i % 4, (i % 4) == 0, 1'b0);
      end
      step(); step();
      chk_ctd("p3_pre_reload", 2, 1'b0, 1'b0);
      load = 1'b1; load_period = 24'd1;
      step();
      chk_ctd("ld1", 0, 1'b0, 1'b0);
      load = 1'b0;
      step();
      chk_ctd("p1_e1", 1, 1'b0, 1'b0);
      step();
      chk_ctd("p1_e2", 0, 1'b1, 1'b0);

      // One-shot P=5.
      load = 1'b1; load_period = 24'd5; mode = 1'b1;
      step();
      load = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_ctd($sformatf("os_e%0d", i), i, 1'b0, 1'b0);
      end
      step();
      chk_ctd("os_e6", 0, 1'b1, 1'b1);
      for (int i = 1; i <= 20; i++) begin
         step();
         chk_ctd($sformatf("os_hold%0d", i), 0, 1'b0, 1'b1);
      end
      chk("os_hold.running", 32'(running), 32'd0);
      clear = 1'b1;
      step();
      chk_ctd("os_clear", 0, 1'b0, 1'b0);
      chk("os_clear.running", 32'(running), 32'd0);
      clear = 1'b0;
      step();
      chk_ctd("os_resume", 1, 1'b0, 1'b0);
      chk("os_resume.running", 32'(running), 32'd1);
      mode = 1'b0;

      // P=7 with a 3-edge pause at count 4: tick after overall edge 11.
      load = 1'b1; load_period = 24'd7;
      step();
      load = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         chk_ctd($sformatf("p7_e%0d", i), i, 1'b0, 1'b0);
      end
      enable = 1'b0;
      for (int i = 5; i <= 7; i++) begin
         step();
         chk_ctd($sformatf("p7_pause_e%0d", i), 4, 1'b0, 1'b0);
         chk("p7_pause.running", 32'(running), 32'd0);
      end
      enable = 1'b1;
      for (int i = 8; i <= 10; i++) begin
         step();
         chk_ctd($sformatf("p7_e%0d", i), i - 3, 1'b0, 1'b0);
      end
      chk("p7.running", 32'(running), 32'd1);
      step();
      chk_ctd("p7_e11", 0, 1'b1, 1'b0);

      // Asynchronous reset while tick is high, then default period resumes.
      load = 1'b1; load_period = 24'd3;
      step();
      load = 1'b0;
      for (int i = 1; i <= 4; i++) step();
      chk_ctd("pre_rst", 0, 1'b1, 1'b0);
      n_rst = 1'b0;
      #2;
      chk_ctd("async_rst", 0, 1'b0, 1'b0);
      n_rst = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         step();
         chk_ctd($sformatf("post_rst_e%0d", i), i % 10, i == 10, 1'b0);
      end

      // P=0 periodic: tick every enabled edge.
      load = 1'b1; load_period = 24'd0;
      step();
      chk_ctd("ld0", 0, 1'b0, 1'b0);
      load = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step();
         chk_ctd($sformatf("p0_e%0d", i), 0, 1'b1, 1'b0);
      end
      enable = 1'b0;
      step();
      chk_ctd("p0_pause", 0, 1'b0, 1'b0);

`ifdef TIMER_CAPTURE_EN
      enable = 1'b1;
      load = 1'b1; load_period = 24'd9;
      step();
      load = 1'b0;
      for (int i = 1; i <= 4; i++) step();
      chk_ctd("cap_pre", 4, 1'b0, 1'b0);
      capture = 1'b1;
      step();
      capture = 1'b0;
      chk("cap_val", 32'(capture_val), 32'd4);
      chk("cap_count", 32'(count), 32'd5);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("cap_after_clear", 32'(capture_val), 32'd4);
      chk("cap_clear_count", 32'(count), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
